// File: rtl/pwm_multi_driver.sv
// Multi-channel PWM engine: one shared period counter, per-channel static or breathing duty,
// with duty/mode writes staged and applied on period boundaries.
module pwm_multi_driver #(
    parameter int PWM_BITS = 12,
    parameter int CHANNELS = 4,
    parameter int CH_W     = 2,
    parameter int STEP     = 16,
    parameter int DIV_BITS = 8
) (
    input  logic                         clk_pwm,
    input  logic                         areset_n,
    input  logic                         enable,
    input  logic                         wr_en,
    input  logic [CH_W-1:0]              wr_ch,
    input  logic [PWM_BITS-1:0]          wr_duty,
    input  logic                         wr_mode,
    input  logic [DIV_BITS-1:0]          inc_div,
    output logic [CHANNELS-1:0]          pwm_out,
    output logic                         period_start,
    output logic [CHANNELS*PWM_BITS-1:0] duty_out
);

    localparam logic [PWM_BITS-1:0] MAX    = '1;
    localparam logic [PWM_BITS:0]   MAX_W  = {1'b0, MAX};
    localparam logic [PWM_BITS:0]   STEP_W = (PWM_BITS + 1)'(STEP);
    localparam logic [PWM_BITS-1:0] STEP_D = PWM_BITS'(STEP);

    logic [PWM_BITS-1:0] cnt;
    logic [DIV_BITS-1:0] presc;
    logic [PWM_BITS-1:0] duty_eff    [CHANNELS];
    logic [PWM_BITS-1:0] pend_duty   [CHANNELS];
    logic [PWM_BITS-1:0] breath_duty [CHANNELS];
    logic [CHANNELS-1:0] mode;
    logic [CHANNELS-1:0] dir_down;
    logic [CHANNELS-1:0] pend_mode;
    logic [CHANNELS-1:0] pend_valid;
    logic [CHANNELS-1:0] wr_hit;
    logic [CHANNELS-1:0] breath_dir;
    logic                boundary;
    logic                apply;
    logic                tick;

    assign boundary = enable && (cnt == MAX);
    // While stopped there is no period to wait for, so staged writes land on every edge.
    assign apply    = boundary || !enable;
    assign tick     = boundary && (presc == inc_div);

    // NOTE: every signal assigned in this block gets a default first, so no latch can be inferred.
    always_comb begin
        wr_hit     = '0;
        breath_dir = dir_down;
        for (int i = 0; i < CHANNELS; i++) begin
            breath_duty[i] = duty_eff[i];
            wr_hit[i]      = wr_en && (wr_ch == CH_W'(i));
            if (!dir_down[i]) begin
                if ({1'b0, duty_eff[i]} + STEP_W > MAX_W) begin
                    breath_duty[i] = MAX;
                    breath_dir[i]  = 1'b1;
                end else begin
                    breath_duty[i] = duty_eff[i] + STEP_D;
                end
            end else begin
                if ({1'b0, duty_eff[i]} < STEP_W) begin
                    breath_duty[i] = '0;
                    breath_dir[i]  = 1'b0;
                end else begin
                    breath_duty[i] = duty_eff[i] - STEP_D;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_pwm or negedge areset_n) begin
        if (!areset_n) begin
            cnt          <= '0;
            presc        <= '0;
            period_start <= 1'b0;
            pwm_out      <= '0;
        end else begin
            cnt          <= enable ? cnt + 1'b1 : '0;
            period_start <= boundary;
            if (tick) begin
                presc <= '0;
            end else if (boundary) begin
                presc <= presc + 1'b1;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                pwm_out[i] <= enable && (cnt < duty_eff[i]);
            end
        end
    end

    // NOTE: the per-channel arrays are plain flops rather than a RAM, so they take the async reset.
    always_ff @(posedge clk_pwm or negedge areset_n) begin
        if (!areset_n) begin
            mode       <= '0;
            dir_down   <= '0;
            pend_mode  <= '0;
            pend_valid <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_eff[i]  <= '0;
                pend_duty[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (apply && wr_hit[i]) begin
                    duty_eff[i]   <= wr_duty;
                    mode[i]       <= wr_mode;
                    dir_down[i]   <= 1'b0;
                    pend_valid[i] <= 1'b0;
                end else if (apply && pend_valid[i]) begin
                    duty_eff[i]   <= pend_duty[i];
                    mode[i]       <= pend_mode[i];
                    dir_down[i]   <= 1'b0;
                    pend_valid[i] <= 1'b0;
                end else begin
                    if (wr_hit[i]) begin
                        pend_duty[i]  <= wr_duty;
                        pend_mode[i]  <= wr_mode;
                        pend_valid[i] <= 1'b1;
                    end
                    if (tick && mode[i]) begin
                        duty_eff[i] <= breath_duty[i];
                        dir_down[i] <= breath_dir[i];
                    end
                end
            end
        end
    end

    always_comb begin
        duty_out = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            duty_out[i*PWM_BITS +: PWM_BITS] = duty_eff[i];
        end
    end

endmodule
